// File: rtl/cancid_stream_ctx_bank.sv
// cancid_stream_ctx_bank
//
// Per-stream context bank for one external regex matcher (finger_*).
// The bank saves the matcher's DFA state at the end of each packet and
// restores it at the start of the next packet on the same stream. It
// also keeps a saturating match counter per stream and a saturating
// aggregate counter.
//
// Packet flow: IDLE -> LOAD -> RUN -> COMMIT -> IDLE (4 cycles minimum).
//
// Handshake semantics: there is no backpressure anywhere. pkt_start, eop
// and rd_req are single-cycle qualifiers that are acted on in the cycle
// they are sampled high. pkt_start is only accepted in IDLE; elsewhere it
// raises err_pkt one cycle later. rd_req is accepted every cycle and is
// answered with rd_vld exactly one cycle later.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pkt_start         new packet; sid/new_sid/enable sampled with it
//   sid, new_sid      stream id, "fresh stream" flag (start from state 0)
//   enable            regex enabled for this stream
//   eop               end of packet (acted on in RUN only)
//   m_state_out       matcher current state (saved in COMMIT)
//   m_accept          matcher accept pulse (counted in RUN only)
//   m_state_in(_vld)  state and load strobe to the matcher (LOAD cycle)
//   fired             current packet has matched (sticky)
//   busy              FSM not in IDLE
//   err_pkt           pkt_start seen outside IDLE (one-cycle pulse)
//   rd_req, rd_sid    counter read request
//   rd_vld, rd_count  read response, one cycle after rd_req
//   total_count       aggregate match count
//   dbg_state         FSM state for checkers / debug

module cancid_stream_ctx_bank #(
    parameter int STATE_W = 11,
    parameter int STREAMS = 64,
    parameter int SID_W   = 6,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pkt_start,
    input  logic [SID_W-1:0]   sid,
    input  logic               new_sid,
    input  logic               enable,
    input  logic               eop,
    input  logic [STATE_W-1:0] m_state_out,
    input  logic               m_accept,
    output logic [STATE_W-1:0] m_state_in,
    output logic               m_state_in_vld,
    output logic               fired,
    output logic               busy,
    output logic               err_pkt,
    input  logic               rd_req,
    input  logic [SID_W-1:0]   rd_sid,
    output logic               rd_vld,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COUNT_W-1:0] total_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    // Storage
    logic [STATE_W-1:0] ctx_mem [STREAMS];
    logic [COUNT_W-1:0] cnt_mem [STREAMS];
    logic [STREAMS-1:0] vld_bits;

    // Packet context latched on an accepted pkt_start
    logic [SID_W-1:0]   lat_sid;
    logic               lat_new;
    logic               lat_en;   // enable and sid in range
    logic               lat_ok;   // sid in range

    logic [STATE_W-1:0] ctx_cur;
    logic               vld_cur;
    logic [COUNT_W-1:0] cnt_cur;
    logic [COUNT_W-1:0] cnt_nxt;
    logic [COUNT_W-1:0] total_nxt;
    logic [COUNT_W-1:0] rd_val;
    logic               commit_we;

    function automatic logic sid_ok(input logic [SID_W-1:0] s);
        return (32'(s) < 32'(STREAMS));
    endfunction

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pkt_start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_RUN;
            S_RUN:    if (eop) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Guarded reads of the per-stream entries selected by the latched sid.
    // Out-of-range ids never index the arrays.
    always_comb begin
        ctx_cur = '0;
        vld_cur = 1'b0;
        cnt_cur = '0;
        if (lat_ok) begin
            ctx_cur = ctx_mem[lat_sid];
            vld_cur = vld_bits[lat_sid];
            cnt_cur = cnt_mem[lat_sid];
        end
    end

    always_comb begin
        rd_val = '0;
        if (sid_ok(rd_sid)) rd_val = cnt_mem[rd_sid];
    end

    // Saturating increments by the sticky fired flag
    always_comb begin
        cnt_nxt   = cnt_cur;
        total_nxt = total_count;
        if (fired && (cnt_cur != CNT_MAX))     cnt_nxt   = cnt_cur + COUNT_W'(1);
        if (fired && (total_count != CNT_MAX)) total_nxt = total_count + COUNT_W'(1);
    end

    assign commit_we = (state == S_COMMIT) && lat_en;

    // Matcher load: a fresh stream or one never committed starts from 0.
    // The outputs are decoded from the state register, so they are
    // glitch-free and appear in the cycle after pkt_start.
    always_comb begin
        m_state_in     = '0;
        m_state_in_vld = 1'b0;
        if (state == S_LOAD) begin
            m_state_in_vld = 1'b1;
            m_state_in     = (lat_new || !vld_cur) ? '0 : ctx_cur;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Control, counters and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_sid     <= '0;
            lat_new     <= 1'b0;
            lat_en      <= 1'b0;
            lat_ok      <= 1'b0;
            fired       <= 1'b0;
            err_pkt     <= 1'b0;
            vld_bits    <= '0;
            total_count <= '0;
            rd_vld      <= 1'b0;
            rd_count    <= '0;
            for (int i = 0; i < STREAMS; i++) cnt_mem[i] <= '0;
        end else begin
            state   <= state_nxt;
            err_pkt <= pkt_start && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (pkt_start) begin
                        lat_sid <= sid;
                        lat_new <= new_sid;
                        lat_ok  <= sid_ok(sid);
                        lat_en  <= enable && sid_ok(sid);
                        fired   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (m_accept) fired <= 1'b1;
                end
                S_COMMIT: begin
                    // A disabled (or out-of-range) packet leaves no trace.
                    if (!lat_en) fired <= 1'b0;
                end
                default: ;
            endcase

            if (commit_we) begin
                vld_bits[lat_sid] <= 1'b1;
                cnt_mem[lat_sid]  <= cnt_nxt;
                total_count       <= total_nxt;
            end

            // Read-first: rd_val samples cnt_mem before this edge's commit.
            rd_vld <= rd_req;
            if (rd_req) rd_count <= rd_val;
        end
    end

    // Context RAM: no reset, contents are qualified by vld_bits.
    always_ff @(posedge clk) begin
        if (commit_we) ctx_mem[lat_sid] <= m_state_out;
    end

endmodule

// File: tb/tb_cancid_stream_ctx_bank.sv
// Self-checking bench for cancid_stream_ctx_bank. A small model of the
// stream table (per-stream count, saved state, committed flag, total)
// predicts every observed value. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point.

module tb_cancid_stream_ctx_bank;

    localparam int STATE_W = 11;
    localparam int STREAMS = 48;
    localparam int SID_W   = 6;
    localparam int COUNT_W = 4;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               pkt_start;
    logic [SID_W-1:0]   sid;
    logic               new_sid;
    logic               enable;
    logic               eop;
    logic [STATE_W-1:0] m_state_out;
    logic               m_accept;
    logic [STATE_W-1:0] m_state_in;
    logic               m_state_in_vld;
    logic               fired;
    logic               busy;
    logic               err_pkt;
    logic               rd_req;
    logic [SID_W-1:0]   rd_sid;
    logic               rd_vld;
    logic [COUNT_W-1:0] rd_count;
    logic [COUNT_W-1:0] total_count;
    logic [1:0]         dbg_state;

    cancid_stream_ctx_bank #(
        .STATE_W(STATE_W), .STREAMS(STREAMS), .SID_W(SID_W), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .sid(sid),
        .new_sid(new_sid), .enable(enable), .eop(eop),
        .m_state_out(m_state_out), .m_accept(m_accept),
        .m_state_in(m_state_in), .m_state_in_vld(m_state_in_vld),
        .fired(fired), .busy(busy), .err_pkt(err_pkt),
        .rd_req(rd_req), .rd_sid(rd_sid), .rd_vld(rd_vld),
        .rd_count(rd_count), .total_count(total_count), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model and scoreboard
    int                 exp_cnt [STREAMS];
    int                 exp_ctx [STREAMS];
    bit                 exp_vld [STREAMS];
    int                 exp_total;
    logic [COUNT_W-1:0] exp_q[$];

    int total_checks;
    int bad;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < STREAMS; i++) begin
            exp_cnt[i] = 0;
            exp_ctx[i] = 0;
            exp_vld[i] = 1'b0;
        end
        exp_total = 0;
    endtask

    task automatic idle_inputs();
        pkt_start   = 1'b0;
        sid         = '0;
        new_sid     = 1'b0;
        enable      = 1'b0;
        eop         = 1'b0;
        m_accept    = 1'b0;
        m_state_out = '0;
        rd_req      = 1'b0;
        rd_sid      = '0;
    endtask

    // Driver: one counter read, checked against the scoreboard
    task automatic do_read(input int s);
        logic [COUNT_W-1:0] want;
        rd_req = 1'b1;
        rd_sid = SID_W'(s);
        if (s < STREAMS) exp_q.push_back(COUNT_W'(exp_cnt[s]));
        else             exp_q.push_back('0);
        tick();
        rd_req = 1'b0;
        want = exp_q.pop_front();
        total_checks++;
        if (rd_vld !== 1'b1) begin
            bad++; $display("FAIL rd_vld sid=%0d got=%b want=1", s, rd_vld);
        end
        total_checks++;
        if (rd_count !== want) begin
            bad++; $display("FAIL rd_count sid=%0d got=%0d want=%0d", s, rd_count, want);
        end
        total_checks++;
        if (total_count !== COUNT_W'(exp_total)) begin
            bad++; $display("FAIL total_count got=%0d want=%0d", total_count, exp_total);
        end
    endtask

    // Driver: one complete packet with checks along the way.
    // acc_mode: 0 none, 1 random, 2 only with eop, 3 only in first RUN cycle
    task automatic send_pkt(input int s, input bit nw, input bit en, input int run_len,
                            input int acc_mode, input int so, input bit inj_err,
                            input bit rd_commit);
        int exp_load;
        bit exp_fired;
        bit acc;
        int old_cnt;
        exp_load = 0;
        if (s < STREAMS && !nw && exp_vld[s]) exp_load = exp_ctx[s];
        old_cnt = (s < STREAMS) ? exp_cnt[s] : 0;

        // pkt_start cycle: eop/m_accept here must be ignored
        pkt_start   = 1'b1;
        sid         = SID_W'(s);
        new_sid     = nw;
        enable      = en;
        eop         = 1'(($urandom_range(0, 1)));
        m_accept    = 1'(($urandom_range(0, 1)));
        m_state_out = STATE_W'(so);
        tick();
        pkt_start = 1'b0;
        total_checks++;
        if (m_state_in_vld !== 1'b1) begin
            bad++; $display("FAIL load_vld sid=%0d got=%b want=1", s, m_state_in_vld);
        end
        total_checks++;
        if (m_state_in !== STATE_W'(exp_load)) begin
            bad++; $display("FAIL load_state sid=%0d got=%h want=%h", s, m_state_in, exp_load);
        end
        total_checks++;
        if (busy !== 1'b1 || fired !== 1'b0) begin
            bad++; $display("FAIL load_flags busy=%b fired=%b want busy=1 fired=0", busy, fired);
        end

        // LOAD cycle: eop/m_accept ignored
        eop      = 1'(($urandom_range(0, 1)));
        m_accept = 1'(($urandom_range(0, 1)));
        tick();
        total_checks++;
        if (m_state_in_vld !== 1'b0) begin
            bad++; $display("FAIL load_vld_len got=%b want=0", m_state_in_vld);
        end

        exp_fired = 1'b0;
        for (int i = 0; i < run_len; i++) begin
            case (acc_mode)
                1:       acc = 1'(($urandom_range(0, 1)));
                2:       acc = (i == run_len - 1);
                3:       acc = (i == 0);
                default: acc = 1'b0;
            endcase
            m_accept = acc;
            eop      = (i == run_len - 1);
            if (inj_err && i == 0) begin
                pkt_start = 1'b1;
                sid       = SID_W'((s + 7) % STREAMS);
                new_sid   = 1'b1;
                enable    = ~en;
            end
            tick();
            pkt_start = 1'b0;
            if (acc) exp_fired = 1'b1;
            total_checks++;
            if (fired !== exp_fired) begin
                bad++; $display("FAIL run_fired cyc=%0d got=%b want=%b", i, fired, exp_fired);
            end
            total_checks++;
            if (err_pkt !== (inj_err && i == 0)) begin
                bad++; $display("FAIL err_pkt cyc=%0d got=%b want=%b", i, err_pkt, inj_err && i == 0);
            end
        end

        // COMMIT cycle
        m_accept = 1'b0;
        eop      = 1'b0;
        total_checks++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL commit_busy got=%b want=1", busy);
        end
        if (rd_commit) begin
            rd_req = 1'b1;
            rd_sid = SID_W'(s);
        end
        tick();
        rd_req = 1'b0;
        if (rd_commit) begin
            total_checks++;
            if (rd_vld !== 1'b1 || rd_count !== COUNT_W'(old_cnt)) begin
                bad++; $display("FAIL read_first vld=%b got=%0d want=%0d", rd_vld, rd_count, old_cnt);
            end
        end

        // Model update
        if (en && s < STREAMS) begin
            exp_ctx[s] = so & ((1 << STATE_W) - 1);
            exp_vld[s] = 1'b1;
            if (exp_fired) begin
                exp_cnt[s] = (exp_cnt[s] + 1 > CMAX) ? CMAX : exp_cnt[s] + 1;
                exp_total  = (exp_total + 1 > CMAX) ? CMAX : exp_total + 1;
            end
        end else begin
            exp_fired = 1'b0;
        end

        total_checks++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_busy got=%b want=0", busy);
        end
        total_checks++;
        if (fired !== exp_fired) begin
            bad++; $display("FAIL post_fired sid=%0d got=%b want=%b", s, fired, exp_fired);
        end
        total_checks++;
        if (err_pkt !== 1'b0) begin
            bad++; $display("FAIL err_pkt_len got=%b want=0", err_pkt);
        end
        total_checks++;
        if (total_count !== COUNT_W'(exp_total)) begin
            bad++; $display("FAIL post_total got=%0d want=%0d", total_count, exp_total);
        end
    endtask

    task automatic test_reset();
        logic [COUNT_W-1:0] held;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        total_checks++;
        if (busy !== 1'b0 || fired !== 1'b0 || err_pkt !== 1'b0 || m_state_in_vld !== 1'b0) begin
            bad++; $display("FAIL reset_flags busy=%b fired=%b err=%b vld=%b want 0", busy, fired, err_pkt, m_state_in_vld);
        end
        total_checks++;
        if (m_state_in !== '0 || rd_vld !== 1'b0 || rd_count !== '0 || total_count !== '0) begin
            bad++; $display("FAIL reset_data state=%h rd_vld=%b rd=%0d total=%0d want 0", m_state_in, rd_vld, rd_count, total_count);
        end
        do_read(0);
        do_read(5);
        do_read(STREAMS - 1);
        held = rd_count;
        tick();
        total_checks++;
        if (rd_vld !== 1'b0 || rd_count !== held) begin
            bad++; $display("FAIL rd_hold vld=%b got=%0d want=%0d", rd_vld, rd_count, held);
        end
    endtask

    task automatic test_first();
        send_pkt(5, 1'b1, 1'b1, 3, 3, 'h1A3, 1'b0, 1'b0);
        do_read(5);
    endtask

    task automatic test_restore();
        send_pkt(5, 1'b0, 1'b1, 2, 0, 'h055, 1'b0, 1'b0);
        send_pkt(9, 1'b0, 1'b1, 2, 1, int'($urandom_range(0, 2047)), 1'b0, 1'b0);
        send_pkt(5, 1'b0, 1'b1, 1, 0, 'h055, 1'b0, 1'b0);
        do_read(5);
        do_read(9);
    endtask

    task automatic test_disable();
        send_pkt(5, 1'b0, 1'b0, 3, 3, 'h7FF, 1'b0, 1'b0);
        do_read(5);
        send_pkt(5, 1'b0, 1'b1, 1, 0, 'h055, 1'b0, 1'b0);
    endtask

    task automatic test_err_readfirst();
        send_pkt(7, 1'b1, 1'b1, 3, 2, 'h321, 1'b1, 1'b1);
        do_read(7);
        do_read(14);
        send_pkt(7, 1'b0, 1'b1, 2, 2, 'h123, 1'b0, 1'b1);
        do_read(7);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            send_pkt(int'($urandom_range(0, 11)), 1'(($urandom_range(0, 3) == 0)),
                     1'(($urandom_range(0, 3) != 0)), int'($urandom_range(1, 4)), 1,
                     int'($urandom_range(0, 2047)), 1'(($urandom_range(0, 5) == 0)),
                     1'(($urandom_range(0, 2) == 0)));
            if ($urandom_range(0, 1) == 1) begin
                do_read(int'($urandom_range(0, 11)));
                do_read(int'($urandom_range(0, 11)));
            end
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < CMAX + 2; n++) send_pkt(3, 1'b0, 1'b1, 1, 3, n, 1'b0, 1'b0);
        do_read(3);
    endtask

    task automatic test_out_of_range();
        send_pkt(50, 1'b0, 1'b1, 2, 3, 'h2AA, 1'b0, 1'b0);
        do_read(50);
        do_read(STREAMS);
    endtask

    task automatic test_rst_mid();
        pkt_start = 1'b1;
        sid       = SID_W'(5);
        new_sid   = 1'b0;
        enable    = 1'b1;
        tick();
        pkt_start = 1'b0;
        tick();
        m_accept = 1'b1;
        tick();
        m_accept = 1'b0;
        total_checks++;
        if (fired !== 1'b1) begin
            bad++; $display("FAIL rst_mid_fired_pre got=%b want=1", fired);
        end
        rst = 1'b1;
        eop = 1'b1;
        tick();
        rst = 1'b0;
        eop = 1'b0;
        model_clear();
        total_checks++;
        if (busy !== 1'b0 || fired !== 1'b0 || total_count !== '0) begin
            bad++; $display("FAIL rst_mid busy=%b fired=%b total=%0d want 0", busy, fired, total_count);
        end
        do_read(3);
        do_read(5);
        do_read(7);
        do_read(9);
        send_pkt(5, 1'b0, 1'b1, 1, 0, 'h0F0, 1'b0, 1'b0);
    endtask

    initial begin
        total_checks = 0;
        bad          = 0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_first();
        test_restore();
        test_disable();
        test_err_readfirst();
        test_random();
        test_saturate();
        test_out_of_range();
        test_rst_mid();
        if (exp_q.size() != 0) begin
            total_checks++;
            bad++;
            $display("FAIL scoreboard_left entries=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule
